masked_subbytes_seq: RTL and testbench
======================================

Name: masked_subbytes_seq

Overview:
- Byte-serial SubBytes sequencer directly upstream/downstream of the masked pipelined AES S-box.
- Accepts a full masked 128-bit state (SHARES shares), issues one shared byte per cycle into the S-box, tracks in-flight bytes with a valid shift pipe, and reassembles the masked output state.
- Also requests fresh randomness from the mask PRNG on every issue cycle.

Parameters:
- SHARES, 2, number of Boolean shares (>=2).
- SBOX_LATENCY, 5, cycles from S-box input sampling to valid S-box output (>=1).

Ports:
- ClkxCI  input  1  clock, all state updates on rising edge.
- RstxRI  input  1  reset, synchronous, active-high.
- StartxSI  input  1  start pulse; sampled only in IDLE.
- StatexDI  input  128*SHARES  masked input state; share i = [i*128 +: 128], byte b of share i = [i*128+8*b +: 8].
- BusyxSO  output  1  high from the cycle after Start is accepted until Done.
- DonexSO  output  1  one-cycle pulse when StatexDO is complete.
- StatexDO  output  128*SHARES  masked output state, same layout as the input; held until the next accepted Start.
- SboxInxDO  output  8*SHARES  to S-box _XxDI; share i = [i*8 +: 8].
- SboxOutxDI  input  8*SHARES  from S-box _QxDO.
- RndEnxSO  output  1  high in every issue cycle; the PRNG advances the RandomZ/RandomB words on it.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, valid pipe cleared, input/output state registers cleared, both counters 0.
- FSM states:
  - IDLE: StartxSI=1 latches StatexDI into the input register and moves to FEED.
  - FEED: 16 cycles. Issue counter k=0..15. SboxInxDO = byte k of each share. RndEnxSO=1. After k=15, move to DRAIN.
  - DRAIN: wait until the collect counter reaches 16, then move to DONE.
  - DONE: DonexSO=1 for one cycle, clear the input register, return to IDLE.
- Timing: Start is accepted at edge 0. Byte k is issued in cycle 1+k. Its output is present on SboxOutxDI in cycle 1+k+SBOX_LATENCY and is captured at the end of that cycle into output byte k.
- Collection: the collect counter increments on each capture. The valid-pipe tap (depth SBOX_LATENCY) qualifies captures; captures are never qualified by FSM state alone.
- DONE timing: DonexSO is high in cycle 17+SBOX_LATENCY. With defaults this is cycle 22.
- Share hygiene:
  - SboxInxDO is all-zero in every non-FEED cycle.
  - Shares are never XORed together inside the block.
  - Each share path is registered separately.
- Start while BusyxSO=1 or in DONE: ignored, no effect on counters.
- Start in the same cycle that DONE returns to IDLE: ignored. Start is accepted only when the FSM is in IDLE at that edge.
- Reset mid-operation: the synchronous reset wins over every other event. Everything returns to the reset values. In-flight S-box results arriving after reset are discarded because the valid pipe is cleared.
- StatexDO updates byte-wise during collection. It is guaranteed complete only while DonexSO=1 and afterwards, until the next accepted Start.
- Counter widths: 5 bits for issue/collect. No wrap-around: FEED exits at 15, collection stops at 16.

Decomposition:
- Shared package:
  - BYTES_PER_STATE=16.
  - Share/byte slicing helper functions: state byte index to bit offset.
  - FSM state encoding (IDLE, FEED, DRAIN, DONE).
- One sub-module: subbytes_valid_pipe. SBOX_LATENCY-deep valid shift register plus collect counter; outputs the capture strobe and capture index.

Test Plan:
- Delay-line stub S-box (each share delayed 5 cycles, unchanged); share0 bytes 0x00..0x0F, share1 0 → DonexSO only in cycle 22, StatexDO == StatexDI, RndEnxSO high exactly in cycles 1..16.
- Real masked S-box, SHARES=2, share0=0x01 repeated, share1 random R, share0 pre-XORed with R per byte → each recombined output byte = 0x1F (S(0x01)=0x7C without the 0x63 constant); all-zero plaintext → recombined 0x00.
- StartxSI held high for 40 cycles → exactly one Done per 22-cycle transaction; second Start accepted only from IDLE at cycle 23; no counter glitch.
- RstxRI asserted in cycle 10 of FEED for 1 cycle → next cycle all outputs 0, state IDLE; a new Start then completes cleanly, with no late captures from the aborted run.
- SBOX_LATENCY=1 and SBOX_LATENCY=8 builds → Done in cycle 18 and cycle 25 respectively; output state correct.
- Monitor during entire runs → SboxInxDO == 0 outside FEED; StatexDO is never changed after Done until the next accepted Start.

Source files
------------

// File: rtl/masked_subbytes_seq_pkg.sv
// -----------------------------------------------------------------------------
// masked_subbytes_seq_pkg
// Shared definitions for the byte-serial masked SubBytes sequencer:
//   - state geometry (bytes per 128-bit state, counter width)
//   - share/byte slicing helpers for the flat multi-share buses
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package masked_subbytes_seq_pkg;

   localparam int BYTES_PER_STATE = 16;
   localparam int SHARE_BITS      = 8 * BYTES_PER_STATE;
   localparam int CNT_W           = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seqStateT;

   // Bit offset of byte b of share `share` inside a flat multi-share state bus.
   function automatic int byteOfs(input int share, input int b);
      return share * SHARE_BITS + 8 * b;
   endfunction

   // Bit offset of share `share` inside a flat multi-share byte bus.
   function automatic int sboxOfs(input int share);
      return 8 * share;
   endfunction

endpackage

// File: rtl/masked_subbytes_seq_if.sv
// -----------------------------------------------------------------------------
// masked_subbytes_seq_if
// Bundles the sequencer's host handshake, state buses and S-box/PRNG link.
//   StartxSI   start pulse                  StatexDI   masked input state
//   BusyxSO    transaction in progress      DonexSO    output state complete
//   StatexDO   masked output state          SboxInxDO  shared byte to S-box
//   SboxOutxDI shared byte from S-box       RndEnxSO   PRNG advance strobe
// master: the environment (host, S-box, PRNG side); slave: the sequencer.
// -----------------------------------------------------------------------------
interface masked_subbytes_seq_if #(
   parameter int SHARES = 2
);
   logic                    StartxSI;
   logic [128*SHARES-1:0]   StatexDI;
   logic                    BusyxSO;
   logic                    DonexSO;
   logic [128*SHARES-1:0]   StatexDO;
   logic [8*SHARES-1:0]     SboxInxDO;
   logic [8*SHARES-1:0]     SboxOutxDI;
   logic                    RndEnxSO;

   modport master (
      output StartxSI, StatexDI, SboxOutxDI,
      input  BusyxSO, DonexSO, StatexDO, SboxInxDO, RndEnxSO
   );

   modport slave (
      input  StartxSI, StatexDI, SboxOutxDI,
      output BusyxSO, DonexSO, StatexDO, SboxInxDO, RndEnxSO
   );
endinterface

// File: rtl/masked_subbytes_seq_valid_pipe.sv
// -----------------------------------------------------------------------------
// subbytes_valid_pipe
// Tracks bytes in flight through the S-box and counts collected results.
//   ClkxCI        clock
//   RstxRI        synchronous active-high reset
//   IssuexSI      a byte enters the S-box this cycle
//   ClrxSI        clear the collect counter (end of transaction)
//   CapturexSO    S-box output this cycle belongs to an issued byte
//   CaptureIdxxDO byte index the current capture lands in
// -----------------------------------------------------------------------------
module subbytes_valid_pipe
   import masked_subbytes_seq_pkg::*;
#(
   parameter int SBOX_LATENCY = 5
) (
   input  logic             ClkxCI,
   input  logic             RstxRI,
   input  logic             IssuexSI,
   input  logic             ClrxSI,
   output logic             CapturexSO,
   output logic [CNT_W-1:0] CaptureIdxxDO
);

   logic [SBOX_LATENCY-1:0] vldPipeQ;
   logic [CNT_W-1:0]        collectCntQ;

   // The tap alone qualifies a capture; the count limit stops collection at 16.
   assign CapturexSO    = vldPipeQ[SBOX_LATENCY-1] &&
                          (collectCntQ < CNT_W'(BYTES_PER_STATE));
   assign CaptureIdxxDO = collectCntQ;

   always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
         vldPipeQ    <= '0;
         collectCntQ <= '0;
      end else begin
         vldPipeQ[0] <= IssuexSI;
         for (int i = 1; i < SBOX_LATENCY; i++) begin
            vldPipeQ[i] <= vldPipeQ[i-1];
         end
         if (ClrxSI) begin
            collectCntQ <= '0;
         end else if (CapturexSO) begin
            collectCntQ <= collectCntQ + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/masked_subbytes_seq.sv
// -----------------------------------------------------------------------------
// masked_subbytes_seq
// Byte-serial SubBytes sequencer wrapped around a pipelined masked AES S-box.
// Latches a SHARES-share masked 128-bit state, feeds one shared byte per cycle
// to the S-box (strobing the PRNG each issue cycle), and reassembles the
// masked S-box outputs into the output state.
//   ClkxCI  clock            RstxRI  synchronous active-high reset
//   Bus     slave side of masked_subbytes_seq_if (start/busy/done, state
//           in/out, S-box in/out, PRNG enable)
// Shares are kept on separate register paths and never combined here.
// -----------------------------------------------------------------------------
module masked_subbytes_seq
   import masked_subbytes_seq_pkg::*;
#(
   parameter int SHARES       = 2,
   parameter int SBOX_LATENCY = 5
) (
   input  logic                 ClkxCI,
   input  logic                 RstxRI,
   masked_subbytes_seq_if.slave Bus
);

   localparam int STATE_W = SHARE_BITS * SHARES;

   seqStateT             stateQ;
   logic [STATE_W-1:0]   inStateQ;
   logic [STATE_W-1:0]   outStateQ;
   logic [8*SHARES-1:0]  sboxInQ;
   logic [CNT_W-1:0]     issueCntQ;
   logic                 busyQ;
   logic                 doneQ;
   logic                 rndEnQ;

   logic                 issue;
   logic                 clrCollect;
   logic                 capture;
   logic [CNT_W-1:0]     captureIdx;

   assign issue      = (stateQ == FEED);
   assign clrCollect = (stateQ == DONE);

   subbytes_valid_pipe #(
      .SBOX_LATENCY (SBOX_LATENCY)
   ) uValidPipe (
      .ClkxCI        (ClkxCI),
      .RstxRI        (RstxRI),
      .IssuexSI      (issue),
      .ClrxSI        (clrCollect),
      .CapturexSO    (capture),
      .CaptureIdxxDO (captureIdx)
   );

   // Sequencer FSM. Outputs are registered one edge ahead so that byte k is
   // on SboxInxDO, and RndEnxSO is high, exactly while the FSM sits in FEED.
   always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
         stateQ    <= IDLE;
         inStateQ  <= '0;
         sboxInQ   <= '0;
         issueCntQ <= '0;
         busyQ     <= 1'b0;
         doneQ     <= 1'b0;
         rndEnQ    <= 1'b0;
      end else begin
         doneQ <= 1'b0;
         case (stateQ)
            IDLE: begin
               if (Bus.StartxSI) begin
                  inStateQ <= Bus.StatexDI;
                  for (int s = 0; s < SHARES; s++) begin
                     sboxInQ[sboxOfs(s) +: 8] <= Bus.StatexDI[byteOfs(s, 0) +: 8];
                  end
                  issueCntQ <= '0;
                  busyQ     <= 1'b1;
                  rndEnQ    <= 1'b1;
                  stateQ    <= FEED;
               end
            end
            FEED: begin
               if (issueCntQ == CNT_W'(BYTES_PER_STATE - 1)) begin
                  sboxInQ <= '0;
                  rndEnQ  <= 1'b0;
                  stateQ  <= DRAIN;
               end else begin
                  issueCntQ <= issueCntQ + CNT_W'(1);
                  for (int s = 0; s < SHARES; s++) begin
                     sboxInQ[sboxOfs(s) +: 8] <=
                        inStateQ[byteOfs(s, int'(issueCntQ) + 1) +: 8];
                  end
               end
            end
            DRAIN: begin
               // Leave on the edge that captures the last byte so Done follows
               // immediately in the next cycle.
               if (capture && (captureIdx == CNT_W'(BYTES_PER_STATE - 1))) begin
                  busyQ  <= 1'b0;
                  doneQ  <= 1'b1;
                  stateQ <= DONE;
               end
            end
            DONE: begin
               inStateQ  <= '0;
               issueCntQ <= '0;
               stateQ    <= IDLE;
            end
            default: stateQ <= IDLE;
         endcase
      end
   end

   // Output reassembly, one byte per share per capture.
   always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
         outStateQ <= '0;
      end else if (capture) begin
         for (int s = 0; s < SHARES; s++) begin
            outStateQ[byteOfs(s, int'(captureIdx)) +: 8] <= Bus.SboxOutxDI[sboxOfs(s) +: 8];
         end
      end
   end

   assign Bus.BusyxSO   = busyQ;
   assign Bus.DonexSO   = doneQ;
   assign Bus.RndEnxSO  = rndEnQ;
   assign Bus.SboxInxDO = sboxInQ;
   assign Bus.StatexDO  = outStateQ;

endmodule

// File: tb/tb_masked_subbytes_seq.sv
module tb_masked_subbytes_seq;
   localparam int SHARES = 2;
   localparam int NDUT   = 3;

   function automatic int latOf(input int i);
      return (i == 0) ? 5 : (i == 1) ? 1 : 8;
   endfunction

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         startS = 1'b0;
   logic [255:0] stateIn = '0;
   bit           maskMode = 1'b0;
   int           nCmp = 0;
   int           nFail = 0;

   always #5 clk = ~clk;

   masked_subbytes_seq_if #(.SHARES(SHARES)) ifA ();
   masked_subbytes_seq_if #(.SHARES(SHARES)) ifB ();
   masked_subbytes_seq_if #(.SHARES(SHARES)) ifC ();

   masked_subbytes_seq #(.SHARES(SHARES), .SBOX_LATENCY(5)) dutA (
      .ClkxCI(clk), .RstxRI(rst), .Bus(ifA.slave));
   masked_subbytes_seq #(.SHARES(SHARES), .SBOX_LATENCY(1)) dutB (
      .ClkxCI(clk), .RstxRI(rst), .Bus(ifB.slave));
   masked_subbytes_seq #(.SHARES(SHARES), .SBOX_LATENCY(8)) dutC (
      .ClkxCI(clk), .RstxRI(rst), .Bus(ifC.slave));

   assign ifA.StartxSI = startS;  assign ifA.StatexDI = stateIn;
   assign ifB.StartxSI = startS;  assign ifB.StatexDI = stateIn;
   assign ifC.StartxSI = startS;  assign ifC.StatexDI = stateIn;

   // ---------------- reference arithmetic: AES S-box without the 0x63 constant
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbx(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int i = 0; i < 8; i++) begin   // x^254 = inverse in GF(2^8)
         if (i != 0) r = gmul(r, p);
         p = gmul(p, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]};
   endfunction

   function automatic logic [127:0] refSubBytes(input logic [127:0] x);
      logic [127:0] y;
      for (int b = 0; b < 16; b++) y[8*b +: 8] = sbx(x[8*b +: 8]);
      return y;
   endfunction

   // ---------------- stub S-box: delay line, optionally a masked S-box model
   function automatic logic [15:0] stubSbox(input logic [15:0] x);
      logic [7:0] m;
      if (!maskMode) return x;
      m = 8'($urandom);
      return {m, sbx(x[7:0] ^ x[15:8]) ^ m};
   endfunction

   logic [15:0] pipeA [5];
   logic [15:0] pipeB [1];
   logic [15:0] pipeC [8];

   always @(posedge clk) begin
      pipeA[0] <= stubSbox(ifA.SboxInxDO);
      for (int i = 1; i < 5; i++) pipeA[i] <= pipeA[i-1];
      pipeB[0] <= stubSbox(ifB.SboxInxDO);
      pipeC[0] <= stubSbox(ifC.SboxInxDO);
      for (int i = 1; i < 8; i++) pipeC[i] <= pipeC[i-1];
   end
   assign ifA.SboxOutxDI = pipeA[4];
   assign ifB.SboxOutxDI = pipeB[0];
   assign ifC.SboxOutxDI = pipeC[7];

   // ---------------- observation arrays
   logic         done [NDUT];
   logic         busy [NDUT];
   logic         rnd  [NDUT];
   logic [15:0]  sbin [NDUT];
   logic [255:0] sout [NDUT];
   assign done[0] = ifA.DonexSO;   assign done[1] = ifB.DonexSO;   assign done[2] = ifC.DonexSO;
   assign busy[0] = ifA.BusyxSO;   assign busy[1] = ifB.BusyxSO;   assign busy[2] = ifC.BusyxSO;
   assign rnd[0]  = ifA.RndEnxSO;  assign rnd[1]  = ifB.RndEnxSO;  assign rnd[2]  = ifC.RndEnxSO;
   assign sbin[0] = ifA.SboxInxDO; assign sbin[1] = ifB.SboxInxDO; assign sbin[2] = ifC.SboxInxDO;
   assign sout[0] = ifA.StatexDO;  assign sout[1] = ifB.StatexDO;  assign sout[2] = ifC.StatexDO;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      nCmp++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // One full transaction on all three builds; called at #1 after an edge.
   task automatic runTxn(input string name, input bit mode, input logic [255:0] st,
                         input logic [127:0] expRec);
      int           doneCyc [NDUT];
      int           doneCnt [NDUT];
      bit           badIn [NDUT];
      bit           badRnd [NDUT];
      bit           badBusy [NDUT];
      bit           badHold [NDUT];
      logic [255:0] held [NDUT];
      logic [15:0]  expIn;
      string        tag;
      for (int i = 0; i < NDUT; i++) begin
         doneCyc[i] = -1; doneCnt[i] = 0; held[i] = '0;
         badIn[i] = 0; badRnd[i] = 0; badBusy[i] = 0; badHold[i] = 0;
      end
      maskMode = mode;
      stateIn  = st;
      startS   = 1'b1;
      @(posedge clk); #1;
      startS = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c <= 16) expIn = {st[128 + 8*(c-1) +: 8], st[8*(c-1) +: 8]};
         else         expIn = 16'h0000;
         for (int i = 0; i < NDUT; i++) begin
            if (sbin[i] !== expIn) badIn[i] = 1;
            if (rnd[i] !== (c <= 16)) badRnd[i] = 1;
            if (busy[i] !== (c <= 16 + latOf(i))) badBusy[i] = 1;
            if (done[i] === 1'b1) begin
               doneCnt[i]++;
               doneCyc[i] = c;
               held[i] = sout[i];
            end else if (doneCnt[i] > 0 && sout[i] !== held[i]) begin
               badHold[i] = 1;
            end
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < NDUT; i++) begin
         tag = $sformatf("%s/L%0d", name, latOf(i));
         chk({tag, "/done_cycle"}, 256'(doneCyc[i]), 256'(17 + latOf(i)));
         chk({tag, "/done_count"}, 256'(doneCnt[i]), 256'd1);
         chk({tag, "/sbox_in_seq"}, 256'(badIn[i]), 256'd0);
         chk({tag, "/rnd_en_window"}, 256'(badRnd[i]), 256'd0);
         chk({tag, "/busy_window"}, 256'(badBusy[i]), 256'd0);
         chk({tag, "/out_held"}, 256'(badHold[i]), 256'd0);
         chk({tag, "/recombined"}, 256'(held[i][127:0] ^ held[i][255:128]), 256'(expRec));
         if (!mode) chk({tag, "/out_eq_in"}, held[i], st);
      end
   endtask

   typedef struct {
      string        name;
      bit           mode;
      logic [255:0] st;
      logic [127:0] expRec;
   } vecT;

   vecT          vecs [4];
   logic [127:0] r;
   logic [255:0] st;
   int           doneCycA [$];
   int           cntD [NDUT];
   bit           bad;

   initial begin
      // ---- vector table
      vecs[0] = '{"ramp_identity", 1'b0, {128'h0, 128'h0F0E0D0C0B0A09080706050403020100},
                  128'h0F0E0D0C0B0A09080706050403020100};
      r = rand256()[127:0];
      vecs[1] = '{"masked_01", 1'b1, {r, r ^ {16{8'h01}}}, {16{8'h1F}}};
      r = rand256()[127:0];
      vecs[2] = '{"masked_zero", 1'b1, {r, r}, 128'h0};
      st = rand256();
      vecs[3] = '{"random_identity", 1'b0, st, st[127:0] ^ st[255:128]};

      // ---- reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset/busy", 256'(busy[0]), 256'd0);
      chk("reset/done", 256'(done[0]), 256'd0);
      chk("reset/rnd_en", 256'(rnd[0]), 256'd0);
      chk("reset/sbox_in", 256'(sbin[0]), 256'd0);
      chk("reset/state_out", sout[0], 256'd0);
      rst = 1'b0;

      for (int v = 0; v < 4; v++) runTxn(vecs[v].name, vecs[v].mode, vecs[v].st, vecs[v].expRec);

      // ---- randomized masked transactions against the reference model
      for (int n = 0; n < 3; n++) begin
         st = rand256();
         runTxn($sformatf("rand_masked%0d", n), 1'b1, st, refSubBytes(st[127:0] ^ st[255:128]));
      end

      // ---- Start held high for 40 cycles
      maskMode = 1'b0;
      st = rand256();
      stateIn = st;
      startS = 1'b1;
      for (int i = 0; i < NDUT; i++) cntD[i] = 0;
      @(posedge clk); #1;
      for (int c = 1; c <= 60; c++) begin
         for (int i = 0; i < NDUT; i++) begin
            if (done[i] === 1'b1) begin
               cntD[i]++;
               if (i == 0) doneCycA.push_back(c);
            end
         end
         if (c == 23) chk("hold_start/busy_c23", 256'(busy[0]), 256'd0);
         if (c == 24) chk("hold_start/busy_c24", 256'(busy[0]), 256'd1);
         if (c == 40) startS = 1'b0;
         @(posedge clk); #1;
      end
      chk("hold_start/L5_done_count", 256'(cntD[0]), 256'd2);
      chk("hold_start/L1_done_count", 256'(cntD[1]), 256'd3);
      chk("hold_start/L8_done_count", 256'(cntD[2]), 256'd2);
      chk("hold_start/L5_first_done", 256'((doneCycA.size() > 0) ? doneCycA[0] : -1), 256'd22);
      chk("hold_start/L5_second_done", 256'((doneCycA.size() > 1) ? doneCycA[1] : -1), 256'd45);
      chk("hold_start/L5_state_out", sout[0], st);

      // ---- reset in cycle 10 of FEED
      maskMode = 1'b1;
      stateIn = rand256();
      startS = 1'b1;
      @(posedge clk); #1;
      startS = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_reset/busy", 256'(busy[0]), 256'd0);
      chk("mid_reset/done", 256'(done[0]), 256'd0);
      chk("mid_reset/rnd_en", 256'(rnd[0]), 256'd0);
      chk("mid_reset/sbox_in", 256'(sbin[0]), 256'd0);
      chk("mid_reset/state_out", sout[0], 256'd0);
      chk("mid_reset/L1_L8_idle",
          256'({busy[1], busy[2], done[1], done[2], rnd[1], rnd[2], sbin[1], sbin[2]}), 256'd0);
      bad = 0;
      repeat (15) begin
         for (int i = 0; i < NDUT; i++)
            if (done[i] !== 1'b0 || sout[i] !== '0 || busy[i] !== 1'b0) bad = 1;
         @(posedge clk); #1;
      end
      chk("mid_reset/no_late_capture", 256'(bad), 256'd0);
      st = rand256();
      runTxn("after_reset", 1'b1, st, refSubBytes(st[127:0] ^ st[255:128]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
